arc4_encrypt: RTL

- Length-prefixed RC4 encryptor: reads a plaintext message from pt memory, runs key scheduling and keystream generation over an external 256x8 S RAM, writes length-prefixed ciphertext to ct memory.
- Inverse direction of the existing ct-reading decrypt/crack path. Produces ct memory images that the crack datapath consumes in on-chip loopback tests, replacing preloaded memh files.
- Sits beside the crack/decrypt blocks under the task top level and uses the same en/rdy handshake.

---
 rtl/arc4_pkg.sv | 33 +++
 rtl/arc4_if.sv | 35 +++
 rtl/arc4_sbox_ctrl.sv | 128 ++++++++++++
 rtl/arc4_encrypt.sv | 107 ++++++++++
 4 files changed

// File: rtl/arc4_pkg.sv
// arc4_pkg: shared types and helpers for the length-prefixed RC4 encryptor.
//   - top_state_t  : handshake / length / pt-ct traffic FSM states
//   - sbox_state_t : S RAM sequencing states (INIT, KSA_*, PRGA_*)
//   - key_byte()   : big-endian key byte selector (byte 0 = most significant)
package arc4_pkg;

    localparam int KEY_BYTES_DEF = 3;
    localparam int ADDR_W_DEF    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEYSCHED,    // sbox controller runs INIT + KSA
        ST_LEN_RD,
        ST_LEN_WR,
        ST_PRGA_GO,     // request one keystream byte, present pt address
        ST_PRGA_WAIT,   // wait for pad, then write ct
        ST_DONE
    } top_state_t;

    typedef enum logic [3:0] {
        SB_IDLE,
        SB_INIT,
        SB_KSA_RI, SB_KSA_LI, SB_KSA_RJ, SB_KSA_LJ, SB_KSA_WI, SB_KSA_WJ,
        SB_PRGA_RI, SB_PRGA_LI, SB_PRGA_RJ, SB_PRGA_LJ, SB_PRGA_WI, SB_PRGA_WJ,
        SB_PRGA_RT, SB_PRGA_LT
    } sbox_state_t;

    // Key is passed zero-extended to 256 bits so one function serves any key length.
    function automatic logic [7:0] key_byte(input logic [255:0] key, input int nbytes, input int idx);
        return key[8*(nbytes-1-idx) +: 8];
    endfunction

endpackage

// File: rtl/arc4_if.sv
// arc4_if: handshake, key and memory-port bundle of arc4_encrypt.
//   en/rdy/key          start handshake and key
//   s_*                 256x8 S RAM port (1-cycle read latency)
//   pt_addr/pt_rddata   plaintext read port (1-cycle read latency)
//   ct_*                ciphertext write port
// master = environment side, slave = encryptor side.
interface arc4_if
    import arc4_pkg::*;
#(
    parameter int KEY_BYTES = KEY_BYTES_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
);
    logic                   en;
    logic                   rdy;
    logic [8*KEY_BYTES-1:0] key;
    logic [ADDR_W-1:0]      s_addr;
    logic [7:0]             s_rddata;
    logic [7:0]             s_wrdata;
    logic                   s_wren;
    logic [ADDR_W-1:0]      pt_addr;
    logic [7:0]             pt_rddata;
    logic [ADDR_W-1:0]      ct_addr;
    logic [7:0]             ct_wrdata;
    logic                   ct_wren;

    modport master (
        output en, key, s_rddata, pt_rddata,
        input  rdy, s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren
    );

    modport slave (
        input  en, key, s_rddata, pt_rddata,
        output rdy, s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren
    );
endinterface

// File: rtl/arc4_sbox_ctrl.sv
// arc4_sbox_ctrl: owns i/j and every S RAM access.
//   i_start      begin INIT (s[i]=i) followed by KSA; o_ksa_done pulses in the last KSA cycle
//   i_step       produce one keystream byte; o_pad is valid while o_pad_valid=1
//   i_key        latched key, i_s_rddata S RAM read data (1-cycle latency)
//   o_s_addr/o_s_wrdata/o_s_wren  S RAM request
// Every read gets its own address cycle and capture cycle, so a write never
// shares a cycle with a read that depends on it.
module arc4_sbox_ctrl
    import arc4_pkg::*;
#(
    parameter int KEY_BYTES = KEY_BYTES_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_start,
    input  logic                   i_step,
    input  logic [8*KEY_BYTES-1:0] i_key,
    input  logic [7:0]             i_s_rddata,
    output logic [7:0]             o_s_addr,
    output logic [7:0]             o_s_wrdata,
    output logic                   o_s_wren,
    output logic                   o_ksa_done,
    output logic [7:0]             o_pad,
    output logic                   o_pad_valid
);
    localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    sbox_state_t       r_state, w_state_next;
    logic [7:0]        r_i, r_j, r_si, r_sj;
    logic [KIDX_W-1:0] r_kidx;   // i mod KEY_BYTES, tracked incrementally

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SB_IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_si    <= '0;
            r_sj    <= '0;
            r_kidx  <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                SB_IDLE: begin
                    if (i_start) begin
                        r_i    <= '0;
                        r_j    <= '0;
                        r_kidx <= '0;
                    end else if (i_step) begin
                        r_i <= r_i + 8'd1;
                    end
                end
                SB_INIT:   r_i <= r_i + 8'd1;     // wraps to 0 for KSA
                SB_KSA_LI: begin
                    r_si <= i_s_rddata;
                    r_j  <= r_j + i_s_rddata + key_byte(256'(i_key), KEY_BYTES, int'(r_kidx));
                end
                SB_PRGA_LI: begin
                    r_si <= i_s_rddata;
                    r_j  <= r_j + i_s_rddata;
                end
                SB_KSA_LJ, SB_PRGA_LJ: r_sj <= i_s_rddata;
                SB_KSA_WJ: begin
                    r_i    <= r_i + 8'd1;         // i=255 wraps to 0 ready for PRGA
                    r_kidx <= (r_kidx == KIDX_W'(KEY_BYTES-1)) ? '0 : r_kidx + 1'b1;
                    if (r_i == 8'hFF) r_j <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_s_addr     = '0;
        o_s_wrdata   = '0;
        o_s_wren     = 1'b0;
        o_ksa_done   = 1'b0;
        o_pad_valid  = 1'b0;
        case (r_state)
            SB_IDLE: begin
                if (i_start)     w_state_next = SB_INIT;
                else if (i_step) w_state_next = SB_PRGA_RI;
            end
            SB_INIT: begin
                o_s_addr   = r_i;
                o_s_wrdata = r_i;
                o_s_wren   = 1'b1;
                if (r_i == 8'hFF) w_state_next = SB_KSA_RI;
            end
            SB_KSA_RI:  begin o_s_addr = r_i; w_state_next = SB_KSA_LI; end
            SB_KSA_LI:  w_state_next = SB_KSA_RJ;
            SB_KSA_RJ:  begin o_s_addr = r_j; w_state_next = SB_KSA_LJ; end
            SB_KSA_LJ:  w_state_next = SB_KSA_WI;
            SB_KSA_WI: begin
                o_s_addr = r_i; o_s_wrdata = r_sj; o_s_wren = 1'b1;
                w_state_next = SB_KSA_WJ;
            end
            SB_KSA_WJ: begin
                o_s_addr = r_j; o_s_wrdata = r_si; o_s_wren = 1'b1;
                if (r_i == 8'hFF) begin
                    o_ksa_done   = 1'b1;
                    w_state_next = SB_IDLE;
                end else begin
                    w_state_next = SB_KSA_RI;
                end
            end
            SB_PRGA_RI: begin o_s_addr = r_i; w_state_next = SB_PRGA_LI; end
            SB_PRGA_LI: w_state_next = SB_PRGA_RJ;
            SB_PRGA_RJ: begin o_s_addr = r_j; w_state_next = SB_PRGA_LJ; end
            SB_PRGA_LJ: w_state_next = SB_PRGA_WI;
            SB_PRGA_WI: begin
                o_s_addr = r_i; o_s_wrdata = r_sj; o_s_wren = 1'b1;
                w_state_next = SB_PRGA_WJ;
            end
            SB_PRGA_WJ: begin
                o_s_addr = r_j; o_s_wrdata = r_si; o_s_wren = 1'b1;
                w_state_next = SB_PRGA_RT;
            end
            // After the swap s[i]+s[j] is still r_si+r_sj.
            SB_PRGA_RT: begin o_s_addr = r_si + r_sj; w_state_next = SB_PRGA_LT; end
            SB_PRGA_LT: begin o_pad_valid = 1'b1; w_state_next = SB_IDLE; end
            default:    w_state_next = SB_IDLE;
        endcase
    end

    assign o_pad = i_s_rddata;

endmodule

// File: rtl/arc4_encrypt.sv
// arc4_encrypt: length-prefixed RC4 encryptor.
//   clk, rst_n   clock, asynchronous active-low reset
//   bus (slave)  en/rdy handshake, key, S RAM, pt read and ct write ports
// Reads len=pt[0], writes ct[0]=len, then ct[k]=pt[k]^pad for k=1..len.
// pt_addr is held at k for the whole byte so pt_rddata is stable when the pad arrives.
module arc4_encrypt
    import arc4_pkg::*;
#(
    parameter int KEY_BYTES = KEY_BYTES_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic   clk,
    input  logic   rst_n,
    arc4_if.slave  bus
);
    top_state_t             r_state, w_state_next;
    logic [8*KEY_BYTES-1:0] r_key;
    logic [7:0]             r_len, r_k;

    logic       w_start, w_step, w_ksa_done, w_pad_valid, w_s_wren;
    logic [7:0] w_pad, w_s_addr, w_s_wrdata;
    logic       w_rdy, w_ct_wren;
    logic [7:0] w_pt_addr, w_ct_addr, w_ct_wrdata;

    assign w_start = (r_state == ST_IDLE) && bus.en;
    assign w_step  = (r_state == ST_PRGA_GO);

    arc4_sbox_ctrl #(.KEY_BYTES(KEY_BYTES)) u_sbox (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (w_start),
        .i_step      (w_step),
        .i_key       (r_key),
        .i_s_rddata  (bus.s_rddata),
        .o_s_addr    (w_s_addr),
        .o_s_wrdata  (w_s_wrdata),
        .o_s_wren    (w_s_wren),
        .o_ksa_done  (w_ksa_done),
        .o_pad       (w_pad),
        .o_pad_valid (w_pad_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_key   <= '0;
            r_len   <= '0;
            r_k     <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_start) r_key <= bus.key;
            if (r_state == ST_LEN_WR) begin
                r_len <= bus.pt_rddata;
                r_k   <= 8'd1;
            end else if (r_state == ST_PRGA_WAIT && w_pad_valid) begin
                r_k <= r_k + 8'd1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_rdy        = 1'b0;
        w_pt_addr    = '0;
        w_ct_addr    = '0;
        w_ct_wrdata  = '0;
        w_ct_wren    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_rdy = 1'b1;
                if (bus.en) w_state_next = ST_KEYSCHED;
            end
            ST_KEYSCHED: if (w_ksa_done) w_state_next = ST_LEN_RD;
            ST_LEN_RD:   w_state_next = ST_LEN_WR;
            ST_LEN_WR: begin
                w_ct_wren    = 1'b1;
                w_ct_wrdata  = bus.pt_rddata;
                w_state_next = (bus.pt_rddata == 8'd0) ? ST_DONE : ST_PRGA_GO;
            end
            ST_PRGA_GO: begin
                w_pt_addr    = r_k;
                w_state_next = ST_PRGA_WAIT;
            end
            ST_PRGA_WAIT: begin
                w_pt_addr = r_k;
                if (w_pad_valid) begin
                    w_ct_wren    = 1'b1;
                    w_ct_addr    = r_k;
                    w_ct_wrdata  = bus.pt_rddata ^ w_pad;
                    w_state_next = (r_k == r_len) ? ST_DONE : ST_PRGA_GO;
                end
            end
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    assign bus.rdy       = w_rdy;
    assign bus.s_addr    = ADDR_W'(w_s_addr);
    assign bus.s_wrdata  = w_s_wrdata;
    assign bus.s_wren    = w_s_wren;
    assign bus.pt_addr   = ADDR_W'(w_pt_addr);
    assign bus.ct_addr   = ADDR_W'(w_ct_addr);
    assign bus.ct_wrdata = w_ct_wrdata;
    assign bus.ct_wren   = w_ct_wren;

endmodule
